// File: rtl/prog_mem_pkg.sv
// Shared types and helpers for the multi-port program memory.
// Constants describe the default configuration; modules derive their own from parameters.
package prog_mem_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_DEPTH  = 2048;
  localparam int BYTES          = DEF_DATA_WIDTH / 8;
  localparam int WORD_AW        = $clog2(DEF_MEM_DEPTH);
  // Widest word the swap helper handles; callers zero-extend and truncate.
  localparam int MAX_DW         = 256;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    DONE = 1'b1
  } state_t;

  // Reverse the order of the lowest nbytes bytes of word.
  function automatic logic [MAX_DW-1:0] byte_swap(input logic [MAX_DW-1:0] word,
                                                  input int nbytes);
    logic [MAX_DW-1:0] res;
    res = '0;
    for (int b = 0; b < MAX_DW / 8; b++) begin
      if (b < nbytes) res[b*8 +: 8] = word[(nbytes-1-b)*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/prog_mem_rd_port.sv
// One registered fetch port: address decode, error check, write-first bypass,
// endianness conversion and output registers.
module prog_mem_rd_port
  import prog_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int BIG_END_IMG = 0,
  localparam int N_BYTES    = DATA_WIDTH / 8,
  localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  ready,
  output logic [IDX_W-1:0]      word_idx,
  input  logic [DATA_WIDTH-1:0] mem_word,
  input  logic                  wr_fire,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [N_BYTES-1:0]    wr_be_st,
  input  logic [DATA_WIDTH-1:0] wr_data_st,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  err
);

  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] bus_word;
  logic                  bad_addr;

  assign word_idx = addr[2 +: IDX_W];
  assign bad_addr = (addr[1:0] != 2'b00) ||
                    (32'(addr[ADDR_WIDTH-1:2]) >= MEM_DEPTH);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    merged = mem_word;
    for (int b = 0; b < N_BYTES; b++) begin
      if (wr_fire && (wr_idx == word_idx) && wr_be_st[b])
        merged[b*8 +: 8] = wr_data_st[b*8 +: 8];
    end
    if (BIG_END_IMG != 0) bus_word = merged;
    else                  bus_word = DATA_WIDTH'(byte_swap(MAX_DW'(merged), N_BYTES));
  end

  always_comb begin
    valid_d = req && ready;
    err_d   = req && ready && bad_addr;
    data_d  = data_q;
    if (req && ready) data_d = bad_addr ? '0 : bus_word;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign err   = err_q;
  assign data  = data_q;

endmodule

// File: rtl/prog_mem_mp.sv
// Multi-port program memory: word array, byte-enabled loader write port, post-reset clear FSM.
// Define PROG_MEM_PRELOAD_EN to skip the clear sequence; contents then come from the loader port.
module prog_mem_mp
  import prog_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH    = DEF_MEM_DEPTH,
  parameter int NUM_RD_PORTS = 2,
  parameter int BIG_END_IMG  = 0,
  localparam int N_BYTES     = DATA_WIDTH / 8,
  localparam int IDX_W       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_RD_PORTS-1:0]            rd_req,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic                               rd_ready,
  output logic [NUM_RD_PORTS-1:0]            rd_valid,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]            rd_err,
  input  logic                               wr_en,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic [N_BYTES-1:0]                 wr_be,
  output logic                               wr_err,
  output logic                               init_done
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  wr_err_q, wr_err_d;

  logic                  wr_bad;
  logic                  wr_fire;
  logic [IDX_W-1:0]      wr_idx;
  logic [N_BYTES-1:0]    wr_be_st;
  logic [DATA_WIDTH-1:0] wr_data_st;

  logic                  mem_we;
  logic [IDX_W-1:0]      mem_idx;
  logic [N_BYTES-1:0]    mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Clear FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
`ifdef PROG_MEM_PRELOAD_EN
        state_d = DONE;
`else
        if (32'(cnt_q) == MEM_DEPTH - 1) state_d = DONE;
        else                             cnt_d   = cnt_q + IDX_W'(1);
`endif
      end
      DONE:    state_d = DONE;
      default: state_d = INIT;
    endcase
    init_done_d = (state_d == DONE);
  end

  // Loader write decode; storage order is reversed for little-endian images.
  always_comb begin
    wr_bad   = (wr_addr[1:0] != 2'b00) || (32'(wr_addr[ADDR_WIDTH-1:2]) >= MEM_DEPTH);
    wr_fire  = wr_en && init_done_q && !wr_bad && (wr_be != '0);
    wr_err_d = wr_en && (!init_done_q || wr_bad);
    wr_idx   = wr_addr[2 +: IDX_W];
    if (BIG_END_IMG != 0) begin
      wr_be_st   = wr_be;
      wr_data_st = wr_data;
    end else begin
      for (int b = 0; b < N_BYTES; b++) wr_be_st[b] = wr_be[N_BYTES-1-b];
      wr_data_st = DATA_WIDTH'(byte_swap(MAX_DW'(wr_data), N_BYTES));
    end
  end

  always_comb begin
`ifdef PROG_MEM_PRELOAD_EN
    mem_we    = wr_fire;
    mem_idx   = wr_idx;
    mem_be    = wr_be_st;
    mem_wdata = wr_data_st;
`else
    if (state_q == INIT) begin
      mem_we    = 1'b1;
      mem_idx   = cnt_q;
      mem_be    = '1;
      mem_wdata = '0;
    end else begin
      mem_we    = wr_fire;
      mem_idx   = wr_idx;
      mem_be    = wr_be_st;
      mem_wdata = wr_data_st;
    end
`endif
  end

  // NOTE: the array has no reset; contents are established by the clear sequence or the loader.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < N_BYTES; b++) begin
        if (mem_be[b]) mem[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign rd_ready  = init_done_q;
  assign init_done = init_done_q;
  assign wr_err    = wr_err_q;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [IDX_W-1:0] idx;

    prog_mem_rd_port #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH),
      .MEM_DEPTH   (MEM_DEPTH),
      .BIG_END_IMG (BIG_END_IMG)
    ) u_port (
      .clk        (clk),
      .rst        (rst),
      .req        (rd_req[p]),
      .addr       (rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .ready      (init_done_q),
      .word_idx   (idx),
      .mem_word   (mem[idx]),
      .wr_fire    (wr_fire),
      .wr_idx     (wr_idx),
      .wr_be_st   (wr_be_st),
      .wr_data_st (wr_data_st),
      .valid      (rd_valid[p]),
      .data       (rd_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .err        (rd_err[p])
    );
  end

endmodule

// File: tb/tb_prog_mem_mp.sv
// Directed bench for prog_mem_mp: 3 read ports, 32 words, little-endian image.
module tb_prog_mem_mp;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int NP = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     rd_req;
  logic [NP*AW-1:0]  rd_addr;
  logic              rd_ready;
  logic [NP-1:0]     rd_valid;
  logic [NP*DW-1:0]  rd_data;
  logic [NP-1:0]     rd_err;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [3:0]        wr_be;
  logic              wr_err;
  logic              init_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prog_mem_mp #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .MEM_DEPTH    (DEPTH),
    .NUM_RD_PORTS (NP),
    .BIG_END_IMG  (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_err    (rd_err),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .wr_err    (wr_err),
    .init_done (init_done)
  );

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_be;
    logic [2:0]    req;
    logic [AW-1:0] a0, a1, a2;
    logic [2:0]    exp_valid;
    logic [2:0]    exp_err;
    logic [DW-1:0] d0, d1, d2;
    logic          exp_wr_err;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic we, logic [AW-1:0] wa, logic [DW-1:0] wd, logic [3:0] be,
                              logic [2:0] req, logic [AW-1:0] a0, logic [AW-1:0] a1,
                              logic [AW-1:0] a2, logic [2:0] ev, logic [2:0] ee,
                              logic [DW-1:0] d0, logic [DW-1:0] d1, logic [DW-1:0] d2,
                              logic ewe);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.wr_be = be;
    v.req = req; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.exp_valid = ev; v.exp_err = ee; v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.exp_wr_err = ewe;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] actual,
                       input logic [DW-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_req  = '0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_be   = '0;
  endtask

  initial begin
    int done_cycle;
    int valid_cnt;
    bit stray_valid;
    logic [DW-1:0] b2b_exp [8];

    // Held rd_data values are tracked by hand across the table.
    vecs[0]  = mk(0, 13'h000, 32'h0,        4'h0, 3'b111, 13'h03C, 13'h042, 13'h080,
                  3'b111, 3'b110, 32'h0, 32'h0, 32'h0, 0);
    vecs[1]  = mk(1, 13'h040, 32'h11223344, 4'hF, 3'b000, 13'h0, 13'h0, 13'h0,
                  3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 0);
    vecs[2]  = mk(0, 13'h000, 32'h0,        4'h0, 3'b001, 13'h040, 13'h0, 13'h0,
                  3'b001, 3'b000, 32'h11223344, 32'h0, 32'h0, 0);
    vecs[3]  = mk(1, 13'h040, 32'h000000AA, 4'h1, 3'b010, 13'h0, 13'h040, 13'h0,
                  3'b010, 3'b000, 32'h11223344, 32'h112233AA, 32'h0, 0);
    vecs[4]  = mk(1, 13'h041, 32'hFFFFFFFF, 4'hF, 3'b001, 13'h040, 13'h0, 13'h0,
                  3'b001, 3'b000, 32'h112233AA, 32'h112233AA, 32'h0, 1);
    vecs[5]  = mk(0, 13'h000, 32'h0,        4'h0, 3'b100, 13'h0, 13'h0, 13'h040,
                  3'b100, 3'b000, 32'h112233AA, 32'h112233AA, 32'h112233AA, 0);
    vecs[6]  = mk(1, 13'h004, 32'hDEADBEEF, 4'hF, 3'b000, 13'h0, 13'h0, 13'h0,
                  3'b000, 3'b000, 32'h112233AA, 32'h112233AA, 32'h112233AA, 0);
    vecs[7]  = mk(1, 13'h000, 32'hCAFEF00D, 4'hF, 3'b000, 13'h0, 13'h0, 13'h0,
                  3'b000, 3'b000, 32'h112233AA, 32'h112233AA, 32'h112233AA, 0);
    vecs[8]  = mk(0, 13'h000, 32'h0,        4'h0, 3'b111, 13'h000, 13'h004, 13'h000,
                  3'b111, 3'b000, 32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D, 0);
    vecs[9]  = mk(1, 13'h004, 32'h0,        4'h0, 3'b100, 13'h0, 13'h0, 13'h004,
                  3'b100, 3'b000, 32'hCAFEF00D, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    vecs[10] = mk(1, 13'h080, 32'h12345678, 4'hF, 3'b000, 13'h0, 13'h0, 13'h0,
                  3'b000, 3'b000, 32'hCAFEF00D, 32'hDEADBEEF, 32'hDEADBEEF, 1);
    vecs[11] = mk(0, 13'h000, 32'h0,        4'h0, 3'b000, 13'h0, 13'h0, 13'h0,
                  3'b000, 3'b000, 32'hCAFEF00D, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    vecs[12] = mk(1, 13'h008, 32'h55667788, 4'hF, 3'b111, 13'h008, 13'h008, 13'h008,
                  3'b111, 3'b000, 32'h55667788, 32'h55667788, 32'h55667788, 0);
    vecs[13] = mk(0, 13'h000, 32'h0,        4'h0, 3'b001, 13'h07C, 13'h0, 13'h0,
                  3'b001, 3'b000, 32'h0, 32'h55667788, 32'h55667788, 0);
    vecs[14] = mk(0, 13'h000, 32'h0,        4'h0, 3'b011, 13'h07E, 13'h0FC, 13'h0,
                  3'b011, 3'b011, 32'h0, 32'h0, 32'h55667788, 0);

    b2b_exp = '{32'hCAFEF00D, 32'hDEADBEEF, 32'h55667788, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0};

    // Reset state
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    check("reset rd_valid", 32'(rd_valid), 32'h0);
    check("reset rd_data", rd_data[DW-1:0], 32'h0);
    check("reset rd_err", 32'(rd_err), 32'h0);
    check("reset wr_err", 32'(wr_err), 32'h0);
    check("reset init_done", 32'(init_done), 32'h0);
    check("reset rd_ready", 32'(rd_ready), 32'h0);

    // Clear sequence; a read and a write during INIT must be ignored/rejected
    rst = 1'b0;
    done_cycle = -1;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5) begin
        rd_req  = 3'b001;
        wr_en   = 1'b1;
        wr_addr = 13'h000;
        wr_data = 32'hFFFFFFFF;
        wr_be   = 4'hF;
      end
      step();
      if (n == 5) begin
        check("init rd_valid ignored", 32'(rd_valid), 32'h0);
        check("init wr_err pulse", 32'(wr_err), 32'h1);
        idle_inputs();
      end
      if (init_done) begin
        done_cycle = n;
        break;
      end
    end
    check("init_done cycle", 32'(done_cycle), 32'(DEPTH));
    check("rd_ready after init", 32'(rd_ready), 32'h1);

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      wr_en   = vecs[i].wr_en;
      wr_addr = vecs[i].wr_addr;
      wr_data = vecs[i].wr_data;
      wr_be   = vecs[i].wr_be;
      rd_req  = vecs[i].req;
      rd_addr = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
      step();
      check($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d rd_err", i), 32'(rd_err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d rd_data0", i), rd_data[0*DW +: DW], vecs[i].d0);
      check($sformatf("v%0d rd_data1", i), rd_data[1*DW +: DW], vecs[i].d1);
      check($sformatf("v%0d rd_data2", i), rd_data[2*DW +: DW], vecs[i].d2);
      check($sformatf("v%0d wr_err", i), 32'(wr_err), 32'(vecs[i].exp_wr_err));
      if (i == 1) check("storage word16 byte order", dut.mem[16], 32'h44332211);
    end
    idle_inputs();
    check("storage word2 byte order", dut.mem[2], 32'h88776655);

    // Back-to-back fetches on port 0
    valid_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      rd_req  = 3'b001;
      rd_addr = {13'h0, 13'h0, 13'(k * 4)};
      step();
      if (rd_valid[0]) valid_cnt++;
      check($sformatf("b2b data %0d", k), rd_data[DW-1:0], b2b_exp[k]);
    end
    check("b2b valid count", 32'(valid_cnt), 32'd8);

    // Reset during an active read drops rd_valid immediately
    rd_req  = 3'b001;
    rd_addr = '0;
    step();
    check("pre-reset rd_valid", 32'(rd_valid), 32'h1);
    rst = 1'b1;
    #1;
    check("async rst rd_valid", 32'(rd_valid), 32'h0);
    check("async rst init_done", 32'(init_done), 32'h0);
    step();
    rst = 1'b0;

    // Reset again at clear count 7, then a full clear must follow
    stray_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      if (rd_valid != '0) stray_valid = 1'b1;
    end
    rst = 1'b1;
    #1;
    check("mid-init rst init_done", 32'(init_done), 32'h0);
    check("mid-init rst rd_valid", 32'(rd_valid), 32'h0);
    step();
    rst = 1'b0;
    done_cycle = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (!init_done && rd_valid != '0) stray_valid = 1'b1;
      if (init_done) begin
        done_cycle = n;
        break;
      end
    end
    check("re-init done cycle", 32'(done_cycle), 32'(DEPTH));
    check("no valid during INIT", 32'(stray_valid), 32'h0);

    // Previously written words are cleared
    rd_req  = 3'b111;
    rd_addr = {13'h008, 13'h040, 13'h000};
    step();
    check("cleared valid", 32'(rd_valid), 32'h7);
    check("cleared word0", rd_data[0*DW +: DW], 32'h0);
    check("cleared word16", rd_data[1*DW +: DW], 32'h0);
    check("cleared word2", rd_data[2*DW +: DW], 32'h0);
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
